// File: rtl/gftt_seq_if.sv
// Bus bundle for the GFTT frame sequencer.
// Groups the frame control, upstream gradient stream, eigenvalue datapath
// drive/return and the coordinate-tagged result stream.
//   slave  : seen by the sequencer (gftt_seq)
//   master : seen by whatever drives the sequencer (controller, source, datapath)
interface gftt_seq_if;
  localparam int unsigned CW = 11;
  localparam int unsigned DW = 12;
  localparam int unsigned RW = 16;

  // frame control
  logic [CW-1:0]        wdt_m1;
  logic [CW-1:0]        hgt_m1;
  logic                 frame_start;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic                 err;
  // upstream gradients
  logic signed [DW-1:0] s_dx;
  logic signed [DW-1:0] s_dy;
  logic                 s_valid;
  logic                 s_ready;
  // eigenvalue datapath
  logic                 eig_start;
  logic                 eig_enb;
  logic signed [DW-1:0] eig_dx;
  logic signed [DW-1:0] eig_dy;
  logic                 eig_vin;
  logic [RW-1:0]        eig_dout;
  logic                 eig_vout;
  // tagged results
  logic [RW-1:0]        m_data;
  logic [CW-1:0]        m_x;
  logic [CW-1:0]        m_y;
  logic                 m_valid;

  modport slave (
    input  wdt_m1, hgt_m1, frame_start, abort,
    input  s_dx, s_dy, s_valid,
    input  eig_dout, eig_vout,
    output busy, done, err, s_ready,
    output eig_start, eig_enb, eig_dx, eig_dy, eig_vin,
    output m_data, m_x, m_y, m_valid
  );

  modport master (
    output wdt_m1, hgt_m1, frame_start, abort,
    output s_dx, s_dy, s_valid,
    output eig_dout, eig_vout,
    input  busy, done, err, s_ready,
    input  eig_start, eig_enb, eig_dx, eig_dy, eig_vin,
    input  m_data, m_x, m_y, m_valid
  );
endinterface

// File: rtl/gftt_seq.sv
// GFTT frame sequencer.
// Feeds one frame of gradients into the eigenvalue datapath, appends
// FLUSH_ROWS zero rows to push the box filter's vertical latency out, then
// tags each returned result with its (x, y) image coordinate, dropping the
// first FLUSH_ROWS rows of results. A watchdog aborts a frame whose datapath
// stops returning results.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : gftt_seq_if.slave (control, s_* stream, eig_* datapath, m_* results)
module gftt_seq #(
  parameter int unsigned FLUSH_ROWS = 2,
  parameter logic [15:0] TIMEOUT    = 16'd4095
) (
  input logic       clk,
  input logic       rst_n,
  gftt_seq_if.slave bus
);
  localparam int unsigned CW = 11;      // coordinate width
  localparam int unsigned OW = CW + 1;  // output row, includes flush rows
  localparam int unsigned DW = 12;      // gradient width
  localparam int unsigned RW = 16;      // result width
  localparam int unsigned NW = 24;      // expected-result counter
  localparam int unsigned WW = 16;      // watchdog counter

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] wdt_q, wdt_n, hgt_q, hgt_n;
  logic [CW-1:0] ix_q, ix_n, iy_q, iy_n, ox_q, ox_n;
  logic [OW-1:0] orow_q, orow_n;
  logic [NW-1:0] remain_q, remain_n;
  logic [WW-1:0] wdog_q, wdog_n;
  logic          fin_q, fin_n;
  logic          busy_q, busy_n, done_q, done_n, err_q, err_n, s_ready_q, s_ready_n;
  logic          eig_start_q, eig_start_n, eig_enb_q, eig_enb_n, eig_vin_q, eig_vin_n;
  logic [DW-1:0] eig_dx_q, eig_dx_n, eig_dy_q, eig_dy_n;
  logic          m_valid_q, m_valid_n;
  logic [RW-1:0] m_data_q, m_data_n;
  logic [CW-1:0] m_x_q, m_x_n, m_y_q, m_y_n;
  logic          xfer, in_last_col, out_last_col;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wdt_q       <= '0;
      hgt_q       <= '0;
      ix_q        <= '0;
      iy_q        <= '0;
      ox_q        <= '0;
      orow_q      <= '0;
      remain_q    <= '0;
      wdog_q      <= '0;
      fin_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      s_ready_q   <= 1'b0;
      eig_start_q <= 1'b0;
      eig_enb_q   <= 1'b0;
      eig_vin_q   <= 1'b0;
      eig_dx_q    <= '0;
      eig_dy_q    <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_x_q       <= '0;
      m_y_q       <= '0;
    end else begin
      state_q     <= state_n;
      wdt_q       <= wdt_n;
      hgt_q       <= hgt_n;
      ix_q        <= ix_n;
      iy_q        <= iy_n;
      ox_q        <= ox_n;
      orow_q      <= orow_n;
      remain_q    <= remain_n;
      wdog_q      <= wdog_n;
      fin_q       <= fin_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
      err_q       <= err_n;
      s_ready_q   <= s_ready_n;
      eig_start_q <= eig_start_n;
      eig_enb_q   <= eig_enb_n;
      eig_vin_q   <= eig_vin_n;
      eig_dx_q    <= eig_dx_n;
      eig_dy_q    <= eig_dy_n;
      m_valid_q   <= m_valid_n;
      m_data_q    <= m_data_n;
      m_x_q       <= m_x_n;
      m_y_q       <= m_y_n;
    end
  end

  // Next state and next register values
  always_comb begin
    state_n      = state_q;
    wdt_n        = wdt_q;
    hgt_n        = hgt_q;
    ix_n         = ix_q;
    iy_n         = iy_q;
    ox_n         = ox_q;
    orow_n       = orow_q;
    remain_n     = remain_q;
    wdog_n       = '0;
    fin_n        = 1'b0;
    busy_n       = 1'b0;
    done_n       = 1'b0;
    err_n        = 1'b0;
    s_ready_n    = 1'b0;
    eig_start_n  = 1'b0;
    eig_enb_n    = 1'b0;
    eig_vin_n    = 1'b0;
    eig_dx_n     = '0;
    eig_dy_n     = '0;
    m_valid_n    = 1'b0;
    m_data_n     = '0;
    m_x_n        = '0;
    m_y_n        = '0;
    xfer         = bus.s_valid & s_ready_q;
    in_last_col  = (ix_q == wdt_q);
    out_last_col = (ox_q == wdt_q);

    case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          state_n     = RUN;
          wdt_n       = bus.wdt_m1;
          hgt_n       = bus.hgt_m1;
          ix_n        = '0;
          iy_n        = '0;
          ox_n        = '0;
          orow_n      = '0;
          remain_n    = (NW'(bus.hgt_m1) + NW'(FLUSH_ROWS) + NW'(1)) * (NW'(bus.wdt_m1) + NW'(1));
          eig_start_n = 1'b1;
        end
      end
      RUN: begin
        if (xfer) begin
          eig_vin_n = 1'b1;
          eig_dx_n  = bus.s_dx;
          eig_dy_n  = bus.s_dy;
          ix_n      = in_last_col ? '0 : ix_q + CW'(1);
          if (in_last_col) begin
            if (iy_q == hgt_q) begin
              iy_n    = '0;
              state_n = (FLUSH_ROWS == 0) ? DRAIN : FLUSH;
            end else begin
              iy_n = iy_q + CW'(1);
            end
          end
        end
      end
      FLUSH: begin
        // one zero pixel per cycle; iy counts flush rows here
        eig_vin_n = 1'b1;
        ix_n      = in_last_col ? '0 : ix_q + CW'(1);
        if (in_last_col) begin
          if (iy_q == CW'(FLUSH_ROWS) - CW'(1)) begin
            iy_n    = '0;
            state_n = DRAIN;
          end else begin
            iy_n = iy_q + CW'(1);
          end
        end
      end
      default: ;
    endcase

    // Tag returned results; the first FLUSH_ROWS rows are filter warm-up
    if (state_q != IDLE && !fin_q && bus.eig_vout) begin
      ox_n     = out_last_col ? '0 : ox_q + CW'(1);
      orow_n   = out_last_col ? orow_q + OW'(1) : orow_q;
      remain_n = remain_q - NW'(1);
      fin_n    = (remain_q == NW'(1));
      if (orow_q >= OW'(FLUSH_ROWS)) begin
        m_valid_n = 1'b1;
        m_data_n  = bus.eig_dout;
        m_x_n     = ox_q;
        m_y_n     = CW'(orow_q - OW'(FLUSH_ROWS));
      end
    end

    // Drain watchdog: consecutive DRAIN cycles with no result
    if (state_q == DRAIN && !fin_q && !bus.eig_vout) begin
      wdog_n = wdog_q + WW'(1);
      if (wdog_n == TIMEOUT) begin
        done_n  = 1'b1;
        err_n   = 1'b1;
        state_n = IDLE;
      end
    end

    // Last result went out as m_valid last cycle; close the frame now
    if (fin_q) begin
      done_n  = 1'b1;
      state_n = IDLE;
    end

    if (bus.abort && state_q != IDLE) begin
      state_n   = IDLE;
      done_n    = 1'b0;
      err_n     = 1'b0;
      fin_n     = 1'b0;
      eig_vin_n = 1'b0;
      eig_dx_n  = '0;
      eig_dy_n  = '0;
    end

    busy_n    = (state_n != IDLE);
    eig_enb_n = (state_n != IDLE);
    s_ready_n = (state_n == RUN);
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.s_ready   = s_ready_q;
  assign bus.eig_start = eig_start_q;
  assign bus.eig_enb   = eig_enb_q;
  assign bus.eig_vin   = eig_vin_q;
  assign bus.eig_dx    = eig_dx_q;
  assign bus.eig_dy    = eig_dy_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_x       = m_x_q;
  assign bus.m_y       = m_y_q;
endmodule

// File: tb/tb_gftt_seq.sv
// Testbench for gftt_seq: random gradient frames against a coordinate/data
// reference derived from frame geometry, with a FIFO eigenvalue datapath
// stand-in of fixed latency that can be told to stop returning results.
module tb_gftt_seq;
  localparam int unsigned FR  = 2;
  localparam logic [15:0] TMO = 16'd4095;
  localparam int          LAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gftt_seq_if bus ();

  gftt_seq #(.FLUSH_ROWS(FR), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] eigf(input logic [11:0] dx, input logic [11:0] dy);
    return {dx[7:0], dy[7:0]} ^ 16'h5a3c;
  endfunction

  // observation state
  int          cyc = 0;
  int          n_start, n_done, n_errp, n_doneerr;
  int          done_cyc, last_vin_cyc, last_vout_cyc, last_mv_cyc;
  logic [1:0]  at_done;
  logic [23:0] vin_q[$];
  logic [37:0] m_q[$];
  // datapath stand-in
  int          dp_due[$];
  logic [15:0] dp_val[$];
  int          dp_limit = 1000;
  int          dp_ret = 0;
  // stimulus pixels
  logic [11:0] pdx[$];
  logic [11:0] pdy[$];

  // Monitor plus datapath model, evaluated on the falling edge
  initial begin
    int          tmp;
    logic [15:0] v;
    bus.eig_vout = 1'b0;
    bus.eig_dout = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.eig_start) n_start++;
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
        at_done  = {bus.busy, bus.eig_enb};
      end
      if (bus.err) n_errp++;
      if (bus.done && bus.err) n_doneerr++;
      if (bus.m_valid) begin
        m_q.push_back({bus.m_data, bus.m_x, bus.m_y});
        last_mv_cyc = cyc;
      end
      if (bus.eig_vin) begin
        vin_q.push_back({bus.eig_dx, bus.eig_dy});
        last_vin_cyc = cyc;
        dp_due.push_back(cyc + LAT);
        dp_val.push_back(eigf(bus.eig_dx, bus.eig_dy));
      end
      bus.eig_vout = 1'b0;
      bus.eig_dout = '0;
      if (dp_due.size() > 0 && dp_due[0] <= cyc) begin
        tmp = dp_due.pop_front();
        v   = dp_val.pop_front();
        if (dp_ret < dp_limit) begin
          bus.eig_vout  = 1'b1;
          bus.eig_dout  = v;
          last_vout_cyc = cyc;
        end
        dp_ret++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic gen_pixels(input int n);
    pdx.delete();
    pdy.delete();
    for (int i = 0; i < n; i++) begin
      pdx.push_back(12'($urandom));
      pdy.push_back(12'($urandom));
    end
  endtask

  task automatic start_frame(input int w, input int h, input int limit);
    vin_q.delete();
    m_q.delete();
    dp_due.delete();
    dp_val.delete();
    dp_ret = 0;
    dp_limit = limit;
    n_start = 0; n_done = 0; n_errp = 0; n_doneerr = 0;
    done_cyc = 0; last_vin_cyc = 0; last_vout_cyc = 0; last_mv_cyc = 0;
    at_done = 2'b11;
    bus.wdt_m1 = 11'(w - 1);
    bus.hgt_m1 = 11'(h - 1);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    // geometry must have been latched; scramble the live inputs
    bus.wdt_m1 = 11'($urandom);
    bus.hgt_m1 = 11'($urandom);
  endtask

  // mode 0: s_valid held high, 1: toggling, 2: random
  task automatic drive_pixels(input int mode, input bit poke);
    int   idx;
    int   t;
    int   n;
    logic v;
    logic xf;
    idx = 0;
    t = 0;
    n = pdx.size();
    while (idx < n && t < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (t % 2) == 0;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus.s_valid     = v;
      bus.s_dx        = pdx[idx];
      bus.s_dy        = pdy[idx];
      bus.frame_start = poke && (t == 3);
      xf = v && bus.s_ready;
      tick();
      if (xf) idx++;
      t++;
    end
    bus.s_valid     = 1'b0;
    bus.frame_start = 1'b0;
    if (idx < n) chk("feed_budget", 64'(idx), 64'(n));
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while (n_done == 0 && t < budget) begin
      tick();
      t++;
    end
    chk("done_seen", 64'(n_done != 0), 64'(1));
    repeat (5) tick();
  endtask

  task automatic check_frame(input int w, input int h, input int limit);
    int          n, tot, nexp, cnt, src;
    logic [37:0] e;
    logic [23:0] px;
    logic [15:0] d;
    n   = w * h;
    tot = (h + int'(FR)) * w;
    chk("vin_count", 64'(vin_q.size()), 64'(tot));
    cnt = (vin_q.size() < tot) ? vin_q.size() : tot;
    for (int k = 0; k < cnt; k++) begin
      px = (k < n) ? {pdx[k], pdy[k]} : 24'd0;
      chk("vin_pixel", 64'(vin_q[k]), 64'(px));
    end
    nexp = limit - int'(FR) * w;
    if (nexp < 0) nexp = 0;
    if (nexp > n) nexp = n;
    chk("mv_count", 64'(m_q.size()), 64'(nexp));
    cnt = (m_q.size() < nexp) ? m_q.size() : nexp;
    for (int j = 0; j < cnt; j++) begin
      e   = m_q[j];
      src = j + int'(FR) * w;
      d   = (src < n) ? eigf(pdx[src], pdy[src]) : eigf(12'd0, 12'd0);
      chk("m_data", 64'(e[37:22]), 64'(d));
      chk("m_xy", 64'(e[21:0]), 64'({11'(j % w), 11'(j / w)}));
    end
    chk("eig_start_once", 64'(n_start), 64'(1));
    chk("done_once", 64'(n_done), 64'(1));
    chk("err_pulses", 64'(n_errp), 64'(limit < tot));
    chk("busy_enb_at_done", 64'(at_done), 64'(0));
    if (limit >= tot && nexp > 0)
      chk("done_after_last_mv", 64'(done_cyc - last_mv_cyc), 64'(1));
    chk("idle_after", 64'({bus.busy, bus.eig_enb, bus.s_ready, bus.eig_vin}), 64'(0));
  endtask

  initial begin
    int w, h, delta, ref_cyc;
    rst_n = 1'b0;
    bus.wdt_m1 = '0;
    bus.hgt_m1 = '0;
    bus.frame_start = 1'b0;
    bus.abort = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_dx = '0;
    bus.s_dy = '0;
    repeat (3) tick();
    chk("rst_ctrl", 64'({bus.busy, bus.done, bus.err, bus.s_ready, bus.eig_start,
                         bus.eig_enb, bus.eig_vin, bus.m_valid}), 64'(0));
    chk("rst_data", 64'({bus.eig_dx, bus.eig_dy, bus.m_data, bus.m_x, bus.m_y}), 64'(0));
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_ctrl", 64'({bus.busy, bus.s_ready, bus.eig_enb, bus.eig_vin}), 64'(0));

    // 4x2 frame, s_valid held high
    gen_pixels(8);
    start_frame(4, 2, 1000);
    drive_pixels(0, 1'b0);
    wait_done(TMO + 300);
    check_frame(4, 2, 1000);

    // same frame, s_valid toggling, stray frame_start during RUN
    gen_pixels(8);
    start_frame(4, 2, 1000);
    drive_pixels(1, 1'b1);
    wait_done(TMO + 300);
    check_frame(4, 2, 1000);

    // datapath returns only 10 of 16 results -> drain timeout
    gen_pixels(8);
    start_frame(4, 2, 10);
    drive_pixels(0, 1'b0);
    wait_done(TMO + 300);
    check_frame(4, 2, 10);
    chk("done_err_together", 64'(n_doneerr), 64'(1));
    ref_cyc = (last_vin_cyc > last_vout_cyc) ? last_vin_cyc : last_vout_cyc;
    delta   = done_cyc - ref_cyc;
    chk("wdog_delay", (delta >= int'(TMO) && delta <= int'(TMO) + 2) ? 64'(TMO) : 64'(delta),
        64'(TMO));

    // abort during FLUSH; in-flight results then land while IDLE
    gen_pixels(8);
    start_frame(4, 2, 1000);
    drive_pixels(0, 1'b0);
    chk("in_flush", 64'({bus.s_ready, bus.eig_vin, bus.busy}), 64'(3'b011));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_ctrl", 64'({bus.busy, bus.eig_enb, bus.eig_vin, bus.s_ready, bus.done}), 64'(0));
    repeat (20) tick();
    chk("abort_no_done", 64'(n_done), 64'(0));
    chk("idle_vout_ignored", 64'(m_q.size()), 64'(0));

    gen_pixels(8);
    start_frame(4, 2, 1000);
    drive_pixels(2, 1'b0);
    wait_done(TMO + 300);
    check_frame(4, 2, 1000);

    // asynchronous reset in the middle of RUN
    gen_pixels(12);
    start_frame(4, 3, 1000);
    bus.s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.s_dx = pdx[i];
      bus.s_dy = pdy[i];
      tick();
    end
    chk("pre_rst_busy", 64'(bus.busy), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", 64'({bus.busy, bus.done, bus.err, bus.s_ready, bus.eig_start,
                               bus.eig_enb, bus.eig_vin, bus.m_valid}), 64'(0));
    chk("async_rst_data", 64'({bus.eig_dx, bus.eig_dy, bus.m_data, bus.m_x, bus.m_y}), 64'(0));
    bus.s_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("post_rst_idle", 64'({bus.busy, bus.s_ready, bus.eig_enb, bus.m_valid}), 64'(0));
    chk("post_rst_no_mv", 64'(m_q.size()), 64'(0));

    // random geometries, including single-column frames
    for (int r = 0; r < 5; r++) begin
      w = (r == 0) ? 1 : $urandom_range(1, 6);
      h = $urandom_range(1, 5);
      gen_pixels(w * h);
      start_frame(w, h, 1000);
      drive_pixels(2, 1'b0);
      wait_done(TMO + 300);
      check_frame(w, h, 1000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
